// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit:
// opcodes, function codes, ALU/mux select codes, FSM states and the
// one-hot instruction class produced by the decoder.
package mc_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;

  // ALU operation codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  // One-hot instruction class; all zero means undecoded.
  typedef struct packed {
    logic rtype;  // ALU/shift R-type (not jr)
    logic jr;
    logic imm;    // addi/andi/ori/xori/lui
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func -> instruction class and
// the per-instruction datapath attributes the FSM needs.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic [3:0] aluc,
  output logic       regrt,
  output logic       sext,
  output logic       shift,
  output logic       illegal
);

  // Decode opcode (and function for R-type) into class and attributes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    cls   = '0;
    aluc  = ALUC_ADD;
    regrt = 1'b0;
    sext  = 1'b0;
    shift = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADD: begin cls.rtype = 1'b1; aluc = ALUC_ADD; end
          F_SUB: begin cls.rtype = 1'b1; aluc = ALUC_SUB; end
          F_AND: begin cls.rtype = 1'b1; aluc = ALUC_AND; end
          F_OR:  begin cls.rtype = 1'b1; aluc = ALUC_OR;  end
          F_XOR: begin cls.rtype = 1'b1; aluc = ALUC_XOR; end
          F_SLL: begin cls.rtype = 1'b1; aluc = ALUC_SLL; shift = 1'b1; end
          F_SRL: begin cls.rtype = 1'b1; aluc = ALUC_SRL; shift = 1'b1; end
          F_SRA: begin cls.rtype = 1'b1; aluc = ALUC_SRA; shift = 1'b1; end
          F_JR:  cls.jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin cls.imm = 1'b1; aluc = ALUC_ADD; sext = 1'b1; regrt = 1'b1; end
      OP_ANDI: begin cls.imm = 1'b1; aluc = ALUC_AND; regrt = 1'b1; end
      OP_ORI:  begin cls.imm = 1'b1; aluc = ALUC_OR;  regrt = 1'b1; end
      OP_XORI: begin cls.imm = 1'b1; aluc = ALUC_XOR; regrt = 1'b1; end
      OP_LUI:  begin cls.imm = 1'b1; aluc = ALUC_LUI; regrt = 1'b1; end
      OP_LW:   begin cls.lw  = 1'b1; aluc = ALUC_ADD; sext = 1'b1; regrt = 1'b1; end
      OP_SW:   begin cls.sw  = 1'b1; aluc = ALUC_ADD; sext = 1'b1; end
      OP_BEQ:  begin cls.beq = 1'b1; aluc = ALUC_SUB; end
      OP_BNE:  begin cls.bne = 1'b1; aluc = ALUC_SUB; end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: ;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/mc_cu_fsm.sv
// Multi-cycle control unit: sequences IF/ID/EXE/MEM/WB for one
// instruction at a time, stalls on mem_rdy and counts retirements.
module mc_cu_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_rdy,
  output logic             wpc,
  output logic             wir,
  output logic             wmem,
  output logic             wreg,
  output logic             iord,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q, state_d;
  logic       retire;
  iclass_t    cls;
  logic [3:0] dec_aluc;
  logic       dec_regrt, dec_sext, dec_shift, dec_illegal;

  mc_decode u_decode (
    .op      (op),
    .func    (func),
    .cls     (cls),
    .aluc    (dec_aluc),
    .regrt   (dec_regrt),
    .sext    (dec_sext),
    .shift   (dec_shift),
    .illegal (dec_illegal)
  );

  assign state = state_q;

  // State register and retired-instruction counter (synchronous reset).
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!resetn) begin
      state_q <= ST_IF;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and per-state control outputs; write enables gated by reset.
  always_comb begin
    state_d  = ST_IF;
    retire   = 1'b0;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    aluc     = ALUC_ADD;
    pcsource = PC_ALU;
    illegal  = 1'b0;

    case (state_q)
      ST_IF: begin
        alusrcb = SRCB_FOUR;
        if (mem_rdy) begin
          wpc     = 1'b1;
          wir     = 1'b1;
          state_d = ST_ID;
        end else begin
          state_d = ST_IF;
        end
      end

      ST_ID: begin
        if (cls.j || cls.jal) begin
          pcsource = PC_JUMP;
          wpc      = 1'b1;
          retire   = 1'b1;
          if (cls.jal) begin
            wreg = 1'b1;
            jal  = 1'b1;
          end
        end else if (cls.jr) begin
          pcsource = PC_RS;
          wpc      = 1'b1;
          retire   = 1'b1;
        end else if (dec_illegal) begin
          illegal = 1'b1;
        end else begin
          // Branch target PC + (imm<<2) is computed here and latched by the datapath.
          alusrcb = SRCB_BR;
          sext    = 1'b1;
          state_d = ST_EXE;
        end
      end

      ST_EXE: begin
        if (cls.beq || cls.bne) begin
          alusrca = 1'b1;
          aluc    = ALUC_SUB;
          retire  = 1'b1;
          if ((cls.beq && z) || (cls.bne && !z)) begin
            wpc      = 1'b1;
            pcsource = PC_BR;
          end
        end else if (cls.lw || cls.sw) begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          sext    = 1'b1;
          state_d = ST_MEM;
        end else if (cls.rtype) begin
          alusrca = 1'b1;
          aluc    = dec_aluc;
          shift   = dec_shift;
          state_d = ST_WB;
        end else if (cls.imm) begin
          alusrcb = SRCB_IMM;
          sext    = dec_sext;
          aluc    = dec_aluc;
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        iord = 1'b1;
        if (cls.sw) begin
          wmem = 1'b1;
          if (mem_rdy) retire = 1'b1;
          else         state_d = ST_MEM;
        end else if (cls.lw) begin
          state_d = mem_rdy ? ST_WB : ST_MEM;
        end
      end

      ST_WB: begin
        wreg   = 1'b1;
        regrt  = dec_regrt;
        m2reg  = cls.lw;
        retire = 1'b1;
      end

      default: state_d = ST_IF;
    endcase

    // Reset discards the current instruction: nothing is written or retired.
    if (!resetn) begin
      wpc     = 1'b0;
      wir     = 1'b0;
      wmem    = 1'b0;
      wreg    = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_cu_fsm.sv
// Self-checking bench for mc_cu_fsm: per-cycle expected state/controls
// are queued as each instruction is scheduled and compared as the DUT
// steps through it. CNT_W=4 so the retired counter wrap is reachable.
module tb_mc_cu_fsm;
  import mc_pkg::*;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic [5:0]       op = 6'd0, func = 6'd0;
  logic             z = 1'b0, mem_rdy = 1'b1;
  logic             wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0]       alusrcb, pcsource;
  logic [3:0]       aluc;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  mc_cu_fsm #(.CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .illegal(illegal),
    .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [3:0] aluc;
    logic illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] op, func;
    logic       z, rdy, retire;
    logic [2:0] st;
    ctl_t       c;
  } item_t;

  ctl_t act_ctl;
  assign act_ctl = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
                    alusrcb, pcsource, aluc, illegal};

  item_t            sb[$];
  int               n_tests = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_ret = '0;
  string            cur_name = "reset";

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] o, f, input logic zz, rr, input logic [2:0] st,
                      input ctl_t c, input logic ret);
    item_t it;
    it.op = o; it.func = f; it.z = zz; it.rdy = rr; it.st = st; it.c = c; it.retire = ret;
    sb.push_back(it);
  endtask

  function automatic ctl_t if_ctl(input logic rdy);
    ctl_t c = '0;
    c.alusrcb = 2'b01;
    c.wpc = rdy;
    c.wir = rdy;
    return c;
  endfunction

  function automatic ctl_t id_ctl();
    ctl_t c = '0;
    c.alusrcb = 2'b11;
    c.sext = 1'b1;
    return c;
  endfunction

  function automatic ctl_t exe_mem_ctl();
    ctl_t c = '0;
    c.alusrca = 1'b1;
    c.alusrcb = 2'b10;
    c.sext = 1'b1;
    return c;
  endfunction

  task automatic push_if(input logic [5:0] o, f, input int waits);
    for (int i = 0; i < waits; i++) push(o, f, 1'b0, 1'b0, 3'd0, if_ctl(1'b0), 1'b0);
    push(o, f, 1'b0, 1'b1, 3'd0, if_ctl(1'b1), 1'b0);
  endtask

  task automatic push_rtype(input logic [5:0] f, input logic [3:0] al, input logic sh);
    ctl_t c;
    push_if(6'd0, f, 0);
    push(6'd0, f, 1'b0, 1'b0, 3'd1, id_ctl(), 1'b0);
    c = '0; c.alusrca = 1'b1; c.aluc = al; c.shift = sh;
    push(6'd0, f, 1'b1, 1'b0, 3'd2, c, 1'b0);
    c = '0; c.wreg = 1'b1;
    push(6'd0, f, 1'b0, 1'b0, 3'd4, c, 1'b1);
  endtask

  task automatic push_imm(input logic [5:0] o, input logic [3:0] al, input logic sx);
    ctl_t c;
    push_if(o, 6'h2a, 1);
    push(o, 6'h2a, 1'b0, 1'b0, 3'd1, id_ctl(), 1'b0);
    c = '0; c.alusrcb = 2'b10; c.sext = sx; c.aluc = al;
    push(o, 6'h2a, 1'b0, 1'b0, 3'd2, c, 1'b0);
    c = '0; c.wreg = 1'b1; c.regrt = 1'b1;
    push(o, 6'h2a, 1'b0, 1'b0, 3'd4, c, 1'b1);
  endtask

  task automatic push_mem(input logic is_lw, input int if_wait, input int mem_wait);
    ctl_t c;
    logic [5:0] o = is_lw ? OP_LW : OP_SW;
    push_if(o, 6'h11, if_wait);
    push(o, 6'h11, 1'b0, 1'b0, 3'd1, id_ctl(), 1'b0);
    push(o, 6'h11, 1'b0, 1'b0, 3'd2, exe_mem_ctl(), 1'b0);
    c = '0; c.iord = 1'b1; c.wmem = !is_lw;
    for (int i = 0; i < mem_wait; i++) push(o, 6'h11, 1'b0, 1'b0, 3'd3, c, 1'b0);
    push(o, 6'h11, 1'b0, 1'b1, 3'd3, c, !is_lw);
    if (is_lw) begin
      c = '0; c.wreg = 1'b1; c.regrt = 1'b1; c.m2reg = 1'b1;
      push(o, 6'h11, 1'b0, 1'b0, 3'd4, c, 1'b1);
    end
  endtask

  task automatic push_br(input logic [5:0] o, input logic zz, input logic taken);
    ctl_t c;
    push_if(o, 6'h05, 0);
    push(o, 6'h05, zz, 1'b1, 3'd1, id_ctl(), 1'b0);
    c = '0; c.alusrca = 1'b1; c.aluc = 4'b0100;
    if (taken) begin c.wpc = 1'b1; c.pcsource = 2'b01; end
    push(o, 6'h05, zz, 1'b1, 3'd2, c, 1'b1);
  endtask

  task automatic push_jump(input logic [5:0] o, f, input logic is_jal, is_jr);
    ctl_t c;
    push_if(o, f, 0);
    c = '0; c.wpc = 1'b1; c.pcsource = is_jr ? 2'b10 : 2'b11;
    c.wreg = is_jal; c.jal = is_jal;
    push(o, f, 1'b0, 1'b0, 3'd1, c, 1'b1);
  endtask

  task automatic push_ill(input logic [5:0] o, f);
    ctl_t c;
    push_if(o, f, 0);
    c = '0; c.illegal = 1'b1;
    push(o, f, 1'b0, 1'b1, 3'd1, c, 1'b0);
  endtask

  // Drive one queued cycle at a time; compare on the falling edge.
  task automatic run_sb();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      op = it.op; func = it.func; z = it.z; mem_rdy = it.rdy;
      @(negedge clock);
      check({cur_name, ".state"}, 32'(state), 32'(it.st));
      check({cur_name, ".ctl"}, 32'(act_ctl), 32'(it.c));
      check({cur_name, ".retired"}, 32'(retired), 32'(exp_ret));
      @(posedge clock);
      if (it.retire) exp_ret = exp_ret + 1'b1;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two clocks with mem_rdy high: IF must not write.
    resetn = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset.state", 32'(state), 32'd0);
    check("reset.retired", 32'(retired), 32'd0);
    check("reset.wen", 32'({wpc, wir, wmem, wreg, illegal}), 32'd0);
    resetn = 1'b1;

    cur_name = "add";  push_rtype(F_ADD, 4'b0000, 1'b0); run_sb();
    cur_name = "sub";  push_rtype(F_SUB, 4'b0100, 1'b0); run_sb();
    cur_name = "sll";  push_rtype(F_SLL, 4'b0011, 1'b1); run_sb();
    cur_name = "sra";  push_rtype(F_SRA, 4'b1111, 1'b1); run_sb();
    cur_name = "addi"; push_imm(OP_ADDI, 4'b0000, 1'b1); run_sb();
    cur_name = "ori";  push_imm(OP_ORI,  4'b0101, 1'b0); run_sb();
    cur_name = "lui";  push_imm(OP_LUI,  4'b0110, 1'b0); run_sb();
    cur_name = "lw";   push_mem(1'b1, 0, 2); run_sb();
    cur_name = "sw";   push_mem(1'b0, 1, 1); run_sb();
    cur_name = "beq_t";  push_br(OP_BEQ, 1'b1, 1'b1); run_sb();
    cur_name = "beq_nt"; push_br(OP_BEQ, 1'b0, 1'b0); run_sb();
    cur_name = "bne_nt"; push_br(OP_BNE, 1'b1, 1'b0); run_sb();
    cur_name = "bne_t";  push_br(OP_BNE, 1'b0, 1'b1); run_sb();
    cur_name = "ill_op";   push_ill(6'b111111, 6'd0); run_sb();
    cur_name = "ill_func"; push_ill(6'd0, 6'b111111); run_sb();
    cur_name = "j";    push_jump(OP_J, 6'd0, 1'b0, 1'b0); run_sb();
    cur_name = "jal";  push_jump(OP_JAL, 6'd0, 1'b1, 1'b0); run_sb();
    cur_name = "jr";   push_jump(6'd0, F_JR, 1'b0, 1'b1); run_sb();

    // Sixteen instructions retired above: the 4-bit counter is back at zero.
    check("wrap16", 32'(retired), 32'd0);
    cur_name = "post_wrap"; push_jump(OP_J, 6'd0, 1'b0, 1'b0); run_sb();
    check("post_wrap.final", 32'(retired), 32'd1);

    // Reset pulsed while sw is waiting in MEM.
    cur_name = "sw_rst";
    push_if(OP_SW, 6'd0, 0);
    push(OP_SW, 6'd0, 1'b0, 1'b0, 3'd1, id_ctl(), 1'b0);
    push(OP_SW, 6'd0, 1'b0, 1'b0, 3'd2, exe_mem_ctl(), 1'b0);
    run_sb();
    mem_rdy = 1'b0;
    #1;
    check("sw_rst.mem_state", 32'(state), 32'd3);
    check("sw_rst.wmem_pre", 32'(wmem), 32'd1);
    resetn = 1'b0;
    #1;
    check("sw_rst.wmem_drop", 32'(wmem), 32'd0);
    @(posedge clock);
    #1;
    exp_ret = '0;
    check("sw_rst.state", 32'(state), 32'd0);
    check("sw_rst.retired", 32'(retired), 32'(exp_ret));
    mem_rdy = 1'b1;
    #1;
    check("sw_rst.wen_in_rst", 32'({wpc, wir, wmem, wreg}), 32'd0);
    resetn = 1'b1;
    #1;
    check("sw_rst.if_resume", 32'({wpc, wir}), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
